mux_sel_arbiter: RTL and testbench
==================================

MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4, meaning the maximum consecutive cycles one requester holds the mux (legal 1..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port req, input, 4, per-requester request; bit i means requester i wants the mux.
REQ-005 SHALL have port in, input, 4, per-requester data bit; bit i is requester i's data.
REQ-006 SHALL have port gnt, output, 4, one-hot registered grant; all zero when no owner.
REQ-007 SHALL have port sel, output, 2, registered binary index of the current owner (the 4:1 mux select).
REQ-008 SHALL have port busy, output, 1, high while any gnt bit is high.
REQ-009 SHALL have port q, output, 1, registered muxed data in[sel], 0 while not busy.

Function
REQ-010 SHALL implement FSM states IDLE (no owner) and BUSY (one owner); busy = (state == BUSY).
REQ-011 SHALL hold a 2-bit round-robin pointer ptr; priority order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-012 IDLE: if req != 0, next edge SHALL grant the first requester in priority order, go BUSY, clear burst counter cnt to 0.
REQ-013 IDLE with req == 0 SHALL remain IDLE, outputs unchanged at reset values.
REQ-014 BUSY: while req[sel]=1 and cnt < MAX_BURST-1, the owner SHALL keep gnt and cnt SHALL increment by 1 per cycle.
REQ-015 Release occurs when req[sel]=0 or cnt == MAX_BURST-1; on the release edge ptr SHALL become sel+1 (mod 4).
REQ-016 On release, if any other requester (excluding the owner) is requesting, the next winner by the new ptr SHALL be granted on the same edge (zero-gap handover), cnt <- 0.
REQ-017 On release by burst expiry with only the owner still requesting, the owner SHALL be re-granted on the same edge, cnt <- 0.
REQ-018 On release with req == 0, the FSM SHALL go IDLE, gnt <- 0, sel holds its last value.
REQ-019 gnt SHALL always be one-hot or zero; sel SHALL equal the index of the set gnt bit whenever busy.
REQ-020 q SHALL be registered: q at cycle t+1 equals in[sel] sampled at cycle t while BUSY at t; latency 1 cycle.
REQ-021 The owner dropping req while another requester asserts req in the same cycle SHALL follow REQ-016.
REQ-022 Request changes of non-owners SHALL NOT affect the current grant before release.
REQ-023 With MAX_BURST=1, every BUSY cycle is a release cycle; grants rotate each cycle among active requesters.

Reset
REQ-024 Asserting rst_n low SHALL immediately force state IDLE, gnt=0, sel=0, busy=0, q=0, cnt=0, ptr=0, regardless of an ongoing burst.
REQ-025 After rst_n deasserts, the first grant SHALL occur no earlier than the first rising edge with rst_n high and req != 0.

Structure
REQ-026 A shared package SHALL hold the FSM state enum (IDLE, BUSY), requester count constant (4) and select width constant (2).
REQ-027 One sub-module rr_pick SHALL be used: combinational, inputs req[3:0] and ptr[1:0], outputs found and idx[1:0].
REQ-028 cnt width SHALL be 4 bits to cover MAX_BURST up to 16.

Verification
REQ-029 Reset mid-burst: owner 2 at cnt=2, pull rst_n low -> gnt=0, sel=0, q=0 same cycle, state IDLE.
REQ-030 Single requester: req=0001, MAX_BURST=4, in[0]=1 -> gnt=0001 one cycle later; re-grant every 4 cycles with no gap; q=1 from cycle 2.
REQ-031 Rotation: req=1111 held, MAX_BURST=2 -> owner sequence 0,0,1,1,2,2,3,3,0 with zero idle cycles.
REQ-032 Early drop: owner 1 drops req after 1 cycle, req[3] high -> gnt 0010 -> 1000 on next edge; ptr=2.
REQ-033 Quiescence: owner 0 drops req, req=0000 -> state IDLE, gnt=0000, busy=0, q=0, sel stays 0.
REQ-034 Data path: owner 3, in toggles 1,0,1 -> q follows 1,0,1 delayed one cycle; non-owner in changes leave q unaffected.

Source files
------------

// File: rtl/mux_sel_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mux_sel_arbiter_pkg
//   Shared definitions for the round-robin mux-select arbiter:
//     N_REQ    : number of requesters (4)
//     SEL_W    : width of the binary select / round-robin pointer (2)
//     CNT_W    : width of the burst counter (4, covers bursts up to 16)
//     state_e  : arbiter FSM state (IDLE = no owner, BUSY = one owner)
//     idx_to_onehot : binary requester index -> one-hot grant vector
// ---------------------------------------------------------------------------
package mux_sel_arbiter_pkg;

   localparam int N_REQ = 4;
   localparam int SEL_W = 2;
   localparam int CNT_W = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
      logic [N_REQ-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/mux_sel_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Purely combinational round-robin picker. Scans the request vector in the
//   order ptr, ptr+1, ptr+2, ptr+3 (mod N_REQ) and reports the first set bit.
//   Ports:
//     req   [N_REQ-1:0] in  : request vector to scan
//     ptr   [SEL_W-1:0] in  : highest-priority position
//     found             out : at least one request bit is set
//     idx   [SEL_W-1:0] out : index of the winner (equals ptr when !found)
// ---------------------------------------------------------------------------
module rr_pick
   import mux_sel_arbiter_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic             found,
   output logic [SEL_W-1:0] idx
);

   logic [SEL_W-1:0] cand;

   always_comb begin
      found = 1'b0;
      idx   = ptr;
      cand  = ptr;
      for (int i = 0; i < N_REQ; i++) begin
         // SEL_W-bit addition wraps naturally, giving the modulo scan order.
         cand = ptr + SEL_W'(i);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/mux_sel_arbiter.sv
// ---------------------------------------------------------------------------
// mux_sel_arbiter
//   Round-robin arbiter driving the select of a 4:1 single-bit mux. One owner
//   holds the mux for at most MAX_BURST consecutive cycles; on release the
//   next requester (by round-robin pointer) takes over on the same edge, so
//   there is no idle gap between owners.
//
//   Handshake: req[i] is a level request; the arbiter answers with gnt[i]
//   on the following rising edge. An owner keeps gnt while req stays high
//   and its burst is not exhausted. Dropping req releases the mux on the
//   next edge. There is no ready/ack from the requester side.
//
//   Parameters:
//     MAX_BURST : max consecutive cycles per ownership (legal 1..16)
//   Ports:
//     clk              in  : clock, all state changes on rising edge
//     rst_n            in  : asynchronous active-low reset
//     req  [3:0]       in  : per-requester request
//     in   [3:0]       in  : per-requester data bit
//     gnt  [3:0]       out : registered one-hot grant, zero when no owner
//     sel  [1:0]       out : registered index of current owner
//     busy             out : high while an owner exists
//     q                out : registered in[sel], 0 while not busy
//     dbg_state        out : current FSM state, for observation only
// ---------------------------------------------------------------------------
module mux_sel_arbiter
   import mux_sel_arbiter_pkg::*;
#(
   parameter int MAX_BURST = 4
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] in,
   output logic [N_REQ-1:0] gnt,
   output logic [SEL_W-1:0] sel,
   output logic             busy,
   output logic             q,
   output state_e           dbg_state
);

   // Last legal counter value; reaching it ends the burst.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

   state_e           state_q, state_n;
   logic [N_REQ-1:0] gnt_q,   gnt_n;
   logic [SEL_W-1:0] sel_q,   sel_n;
   logic [CNT_W-1:0] cnt_q,   cnt_n;
   logic [SEL_W-1:0] ptr_q,   ptr_n;
   logic             q_q,     q_n;

   logic [SEL_W-1:0] sel_inc;
   logic             owner_req;
   logic             burst_done;
   logic             do_release;

   logic [SEL_W-1:0] pick_ptr;
   logic             pick_found;
   logic [SEL_W-1:0] pick_idx;

   assign sel_inc    = sel_q + SEL_W'(1);
   assign owner_req  = req[sel_q];
   assign burst_done = (cnt_q == CNT_LAST);
   assign do_release = (state_q == BUSY) && (!owner_req || burst_done);

   // In IDLE the scan starts at the stored pointer. While BUSY the scan
   // starts just after the owner, which places the owner itself last: other
   // requesters win first, and the owner is only re-picked when it is the
   // sole requester left (burst-expiry re-grant). An owner that dropped req
   // is naturally excluded because its bit is zero.
   assign pick_ptr = (state_q == BUSY) ? sel_inc : ptr_q;

   rr_pick u_rr_pick (
      .req   (req),
      .ptr   (pick_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         cnt_q   <= '0;
         ptr_q   <= '0;
         q_q     <= 1'b0;
      end else begin
         state_q <= state_n;
         gnt_q   <= gnt_n;
         sel_q   <= sel_n;
         cnt_q   <= cnt_n;
         ptr_q   <= ptr_n;
         q_q     <= q_n;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_n = state_q;
      gnt_n   = gnt_q;
      sel_n   = sel_q;
      cnt_n   = cnt_q;
      ptr_n   = ptr_q;
      q_n     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_n = BUSY;
               gnt_n   = idx_to_onehot(pick_idx);
               sel_n   = pick_idx;
               cnt_n   = '0;
            end
         end

         BUSY: begin
            if (!do_release) begin
               cnt_n = cnt_q + CNT_W'(1);
               q_n   = in[sel_q];
            end else begin
               ptr_n = sel_inc;
               if (pick_found) begin
                  // Zero-gap handover (or re-grant of a lone owner). The
                  // data captured on this edge still belongs to the owner
                  // that was active during the cycle.
                  gnt_n = idx_to_onehot(pick_idx);
                  sel_n = pick_idx;
                  cnt_n = '0;
                  q_n   = in[sel_q];
               end else begin
                  // Nobody requesting: go quiet, keep sel at its last value.
                  state_n = IDLE;
                  gnt_n   = '0;
               end
            end
         end

         default: begin
            state_n = IDLE;
            gnt_n   = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   always_comb begin
      busy      = (state_q == BUSY);
      dbg_state = state_q;
   end

   assign gnt = gnt_q;
   assign sel = sel_q;
   assign q   = q_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_sel_arbiter
//   Three arbiters (MAX_BURST = 4, 2, 1) share the same req/in stimulus and
//   are each compared, every cycle, against a behavioural model written with
//   integer owner/pointer/counter variables. Directed steps cover reset,
//   single requester, rotation, early drop, quiescence, data path and
//   reset mid-burst; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_mux_sel_arbiter;
   import mux_sel_arbiter_pkg::*;

   localparam int NI = 3;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req   = 4'b0000;
   logic [3:0] in_d  = 4'b0000;

   logic [3:0] gnt_w  [NI];
   logic [1:0] sel_w  [NI];
   logic       busy_w [NI];
   logic       q_w    [NI];
   state_e     st_w   [NI];

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model per instance
   int m_busy [NI];
   int m_sel  [NI];
   int m_ptr  [NI];
   int m_cnt  [NI];
   int m_q    [NI];

   // ------------------------------------------------------------------
   // Clock
   // ------------------------------------------------------------------
   always #5 clk = ~clk;

   mux_sel_arbiter #(.MAX_BURST(4)) u_mb4 (
      .clk(clk), .rst_n(rst_n), .req(req), .in(in_d),
      .gnt(gnt_w[0]), .sel(sel_w[0]), .busy(busy_w[0]), .q(q_w[0]), .dbg_state(st_w[0])
   );
   mux_sel_arbiter #(.MAX_BURST(2)) u_mb2 (
      .clk(clk), .rst_n(rst_n), .req(req), .in(in_d),
      .gnt(gnt_w[1]), .sel(sel_w[1]), .busy(busy_w[1]), .q(q_w[1]), .dbg_state(st_w[1])
   );
   mux_sel_arbiter #(.MAX_BURST(1)) u_mb1 (
      .clk(clk), .rst_n(rst_n), .req(req), .in(in_d),
      .gnt(gnt_w[2]), .sel(sel_w[2]), .busy(busy_w[2]), .q(q_w[2]), .dbg_state(st_w[2])
   );

   function automatic int mb_of(input int k);
      case (k)
         0:       return 4;
         1:       return 2;
         default: return 1;
      endcase
   endfunction

   // First set bit of r scanning p, p+1, p+2, p+3 (mod 4); -1 if none.
   function automatic int pick(input int r, input int p);
      for (int i = 0; i < 4; i++) begin
         int j;
         j = (p + i) % 4;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NI; k++) begin
         m_busy[k] = 0; m_sel[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0; m_q[k] = 0;
      end
   endtask

   // Apply one rising edge to the model using the inputs sampled there.
   task automatic model_edge();
      int r, d, o, others, w;
      r = int'(req);
      d = int'(in_d);
      for (int k = 0; k < NI; k++) begin
         if (m_busy[k] == 0) begin
            m_q[k] = 0;
            w = pick(r, m_ptr[k]);
            if (w >= 0) begin
               m_busy[k] = 1; m_sel[k] = w; m_cnt[k] = 0;
            end
         end else begin
            o = m_sel[k];
            if (r[o] && m_cnt[k] < mb_of(k) - 1) begin
               m_cnt[k] = m_cnt[k] + 1;
               m_q[k]   = d[o];
            end else begin
               m_ptr[k] = (o + 1) % 4;
               others   = r & ~(1 << o);
               if (others != 0) begin
                  m_sel[k] = pick(others, m_ptr[k]);
                  m_cnt[k] = 0;
                  m_q[k]   = d[o];
               end else if (r[o]) begin
                  m_cnt[k] = 0;
                  m_q[k]   = d[o];
               end else begin
                  m_busy[k] = 0;
                  m_q[k]    = 0;
               end
            end
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ctx);
      for (int k = 0; k < NI; k++) begin
         check($sformatf("%s/mb%0d gnt", ctx, mb_of(k)), 32'(gnt_w[k]),
               (m_busy[k] != 0) ? (32'd1 << m_sel[k]) : 32'd0);
         check($sformatf("%s/mb%0d sel", ctx, mb_of(k)), 32'(sel_w[k]), m_sel[k]);
         check($sformatf("%s/mb%0d busy", ctx, mb_of(k)), 32'(busy_w[k]), m_busy[k]);
         check($sformatf("%s/mb%0d q", ctx, mb_of(k)), 32'(q_w[k]), m_q[k]);
         check($sformatf("%s/mb%0d state", ctx, mb_of(k)), 32'(st_w[k]), m_busy[k]);
      end
   endtask

   // ------------------------------------------------------------------
   // Driver tasks (entered and left at posedge + 1)
   // ------------------------------------------------------------------
   task automatic cycle(input logic [3:0] r, input logic [3:0] d, input string ctx);
      req  = r;
      in_d = d;
      @(posedge clk);
      model_edge();
      #1;
      check_all(ctx);
   endtask

   // Assert reset between edges, check immediately, hold across one edge.
   task automatic reset_mid(input string ctx);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all({ctx, "/async"});
      @(posedge clk);
      #1;
      check_all({ctx, "/held"});
      rst_n = 1'b1;
   endtask

   int exp_rot [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
   int exp_q34 [3] = '{1, 0, 1};

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      // Power-on reset with requests already present: no grant may appear.
      model_reset();
      req = 4'b1111;
      #1;
      check_all("por");
      repeat (2) begin
         @(posedge clk);
         #1;
         check_all("por_held");
      end
      rst_n = 1'b1;

      // Single requester, MAX_BURST=4: gnt next edge, re-grant without gaps.
      for (int i = 0; i < 10; i++) begin
         cycle(4'b0001, 4'b0001, "single");
         check("single/gnt_direct", 32'(gnt_w[0]), 32'h1);
         if (i >= 1) check("single/q_direct", 32'(q_w[0]), 32'h1);
      end

      // Rotation with all requesting, MAX_BURST=2.
      reset_mid("rot_rst");
      for (int i = 0; i < 9; i++) begin
         cycle(4'b1111, 4'b0000, "rot");
         check($sformatf("rot/owner%0d", i), 32'(sel_w[1]), exp_rot[i]);
         check($sformatf("rot/busy%0d", i), 32'(busy_w[1]), 32'h1);
      end

      // Early drop: owner 1 releases after one cycle, requester 3 takes over.
      reset_mid("drop_rst");
      cycle(4'b0010, 4'b0000, "drop");
      check("drop/gnt1", 32'(gnt_w[0]), 32'h2);
      cycle(4'b1010, 4'b0000, "drop");
      check("drop/hold", 32'(gnt_w[0]), 32'h2);
      cycle(4'b1000, 4'b0000, "drop");
      check("drop/handover", 32'(gnt_w[0]), 32'h8);
      cycle(4'b0000, 4'b0000, "drop_idle");
      // Pointer is now 3+1=0 after owner 3 released; requesters 2 and 0.
      cycle(4'b0101, 4'b0000, "drop_ptr");
      check("drop/ptr_winner", 32'(sel_w[0]), 32'h0);

      // Quiescence.
      reset_mid("quiet_rst");
      cycle(4'b0001, 4'b0001, "quiet");
      cycle(4'b0000, 4'b0001, "quiet");
      check("quiet/gnt", 32'(gnt_w[0]), 32'h0);
      check("quiet/busy", 32'(busy_w[0]), 32'h0);
      check("quiet/q", 32'(q_w[0]), 32'h0);
      check("quiet/sel", 32'(sel_w[0]), 32'h0);
      cycle(4'b0000, 4'b0000, "quiet_stay");

      // Data path: owner 3, in[3] toggles 1,0,1, other in bits scramble.
      reset_mid("data_rst");
      cycle(4'b1000, 4'b0000, "data_grant");
      for (int i = 0; i < 3; i++) begin
         logic [3:0] d;
         d    = 4'($urandom_range(0, 7));
         d[3] = exp_q34[i][0];
         cycle(4'b1000, d, "data");
         check($sformatf("data/q%0d", i), 32'(q_w[0]), exp_q34[i]);
      end

      // Reset in the middle of a burst: owner 2 at cnt=2.
      reset_mid("mid_rst0");
      cycle(4'b0100, 4'b1111, "mid");
      cycle(4'b0100, 4'b1111, "mid");
      cycle(4'b0100, 4'b1111, "mid");
      reset_mid("mid_burst");

      // Randomized phase.
      for (int i = 0; i < 400; i++) begin
         logic [3:0] r;
         if ($urandom_range(0, 3) == 0) r = req;
         else                           r = 4'($urandom_range(0, 15));
         cycle(r, 4'($urandom_range(0, 15)), "rand");
         if ($urandom_range(0, 60) == 0) reset_mid("rand_rst");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
